// File: rtl/stream_fifo_arbiter.sv
// Two-requester round-robin burst arbiter feeding a shared streaming FIFO.
// A requester is granted only when the FIFO can absorb a complete burst.
module stream_fifo_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4096,
  parameter int CNT_W = 13,
  parameter int BURST = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [WIDTH-1:0] in0_V_V_TDATA,
  input  logic             in0_V_V_TVALID,
  output logic             in0_V_V_TREADY,
  input  logic [WIDTH-1:0] in1_V_V_TDATA,
  input  logic             in1_V_V_TVALID,
  output logic             in1_V_V_TREADY,
  output logic [WIDTH-1:0] out_V_V_TDATA,
  output logic             out_V_V_TVALID,
  input  logic             out_V_V_TREADY,
  input  logic [CNT_W-1:0] fifo_count,
  output logic             busy,
  output logic             owner,
  output logic [15:0]      stall_cycles
);

  localparam int          BCW         = $clog2(BURST + 1);
  localparam int unsigned SPACE_LIMIT = DEPTH - BURST;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]    stall_q, stall_d;

  logic any_req_s;
  logic space_ok_s;
  logic winner_s;
  logic beat_s;

  // An out-of-range occupancy above DEPTH also fails this check, so it reads as "no space".
  assign any_req_s  = in0_V_V_TVALID | in1_V_V_TVALID;
  assign space_ok_s = (32'(fifo_count) <= SPACE_LIMIT);

  // Pass-through steering: only the owner is connected, and only while bursting.
  always_comb begin
    in0_V_V_TREADY = 1'b0;
    in1_V_V_TREADY = 1'b0;
    out_V_V_TVALID = 1'b0;
    out_V_V_TDATA  = owner_q ? in1_V_V_TDATA : in0_V_V_TDATA;
    if (state_q == ST_BURST) begin
      if (owner_q) begin
        out_V_V_TVALID = in1_V_V_TVALID;
        in1_V_V_TREADY = out_V_V_TREADY;
      end else begin
        out_V_V_TVALID = in0_V_V_TVALID;
        in0_V_V_TREADY = out_V_V_TREADY;
      end
    end else begin
      out_V_V_TVALID = 1'b0;
    end
  end

  assign beat_s = out_V_V_TVALID & out_V_V_TREADY;

  // Winner selection, next-state, beat counting and stall accounting.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    stall_d    = stall_q;
    if (in0_V_V_TVALID && in1_V_V_TVALID) begin
      winner_s = rr_ptr_q;
    end else begin
      winner_s = in1_V_V_TVALID;
    end
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          if (space_ok_s) begin
            state_d    = ST_BURST;
            owner_d    = winner_s;
            beat_cnt_d = '0;
            rr_ptr_d   = ~winner_s;
          end else if (stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
          end else begin
            stall_d = stall_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (beat_s) begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
          if (beat_cnt_q == BCW'(BURST - 1)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BURST;
          end
        end else begin
          state_d = ST_BURST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any partial burst immediately.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      rr_ptr_q   <= 1'b0;
      beat_cnt_q <= '0;
      stall_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      stall_q    <= stall_d;
    end
  end

  assign busy         = (state_q == ST_BURST);
  assign owner        = owner_q;
  assign stall_cycles = stall_q;

endmodule
